// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and sizing helpers for the ALU datapath blocks.
//
// Contents:
//   div_state_t  - state encoding for the sequential divider
//                  (IDLE, RUN, FIX, DONE); FIX is only reachable when the
//                  divider is built with SEQ_DIVIDER_SIGNED_EN defined
//   div_cnt_w()  - width of the divider's step counter for a given
//                  operand width, enough to hold the value WIDTH itself
// ---------------------------------------------------------------------------
package alu_pkg;

  // Explicit two-bit encoding so the state register has a fixed, known
  // layout regardless of which optional features are compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // The counter is loaded with WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//
// The partial remainder is shifted left by one, taking in the next dividend
// bit, and the divisor is trial-subtracted. If the shifted value is at
// least the divisor, the difference becomes the new partial remainder and
// the quotient bit is 1. Otherwise the shifted value is kept (restored)
// and the quotient bit is 0.
//
// Ports:
//   r       in   WIDTH  current partial remainder (always < d)
//   q_msb   in   1      next dividend bit shifted into the remainder
//   d       in   WIDTH  divisor
//   r_next  out  WIDTH  partial remainder after this step
//   q_bit   out  1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  // Because r < d, the shifted value is below 2*d. Whenever the
  // subtraction succeeds, the difference is below d, so it fits in WIDTH
  // bits. The sign of the full-width difference therefore reduces to a
  // plain magnitude compare, and the low WIDTH bits of the difference are
  // enough.
  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted[WIDTH-1:0] - d;
    q_bit   = (shifted >= {1'b0, d});
    r_next  = q_bit ? trial : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider for the ALU. It produces one quotient bit per
// clock and uses a start/busy/done handshake, so the ALU control FSM can
// issue a divide and then stall until the result is ready.
//
// Optional feature (macro SEQ_DIVIDER_SIGNED_EN):
//   Adds the signed_op input. A signed divide works on operand magnitudes
//   and then spends one extra FIX cycle restoring the result signs.
//
// Ports:
//   clk          in   1      system clock, all state on the rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      divide request, honoured only in IDLE or DONE
//   dividend     in   WIDTH  numerator, captured on an accepted start
//   divisor      in   WIDTH  denominator, captured on an accepted start
//   signed_op    in   1      (SEQ_DIVIDER_SIGNED_EN only) two's complement
//   busy         out  1      divide in progress
//   done         out  1      one-cycle pulse, results valid
//   div_by_zero  out  1      captured divisor was zero; held until the
//                            next accepted start
//   quotient     out  WIDTH  result quotient, held until the next result
//   remainder    out  WIDTH  result remainder, held until the next result
// ---------------------------------------------------------------------------
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] step_r;
  logic             step_bit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             accept;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             sign_op_reg;
  logic             neg_q;
  logic             neg_r;

  // A signed divide runs the unsigned datapath on magnitudes. The most
  // negative value maps onto itself, and read as unsigned that is exactly
  // its magnitude.
  always_comb begin
    dividend_mag = (signed_op && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    divisor_mag  = (signed_op && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
  end
`else
  // In the unsigned-only build the operands go straight into the datapath.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
  end
`endif

  // A new divide can only be taken when no divide is in flight.
  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
    q_next = {q_reg[WIDTH-2:0], step_bit};
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  // Main sequencer. {r_reg, q_reg} acts as one shift register: dividend
  // bits leave q_reg at the top, and quotient bits enter it at the bottom.
  // Result registers change only when a result is produced, so the ALU
  // result mux sees stable values between divides. A divide by zero skips
  // the iteration and reports its result right away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_reg    <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      count    <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sign_op_reg <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            r_reg   <= '0;
            q_reg   <= dividend_mag;
            d_reg   <= divisor_mag;
            count   <= CNT_W'(WIDTH);
            dbz_reg <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_op_reg <= signed_op;
            neg_q       <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= signed_op && dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quot_reg <= '1;
              rem_reg  <= dividend;
              dbz_reg  <= 1'b1;
              state    <= DONE;
            end else begin
              state    <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          r_reg <= step_r;
          q_reg <= q_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (sign_op_reg) begin
              state <= FIX;
            end else begin
              quot_reg <= q_next;
              rem_reg  <= step_r;
              state    <= DONE;
            end
`else
            quot_reg <= q_next;
            rem_reg  <= step_r;
            state    <= DONE;
`endif
          end
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        // The quotient is negative when the operand signs differ. The
        // remainder takes the dividend's sign, as in truncating division.
        FIX: begin
          quot_reg <= neg_q ? (~q_reg + WIDTH'(1)) : q_reg;
          rem_reg  <= neg_r ? (~r_reg + WIDTH'(1)) : r_reg;
          state    <= DONE;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register, so done
  // is high for exactly the single DONE cycle.
  always_comb begin
    busy        = (state == RUN) || (state == FIX);
    done        = (state == DONE);
    div_by_zero = dbz_reg;
    quotient    = quot_reg;
    remainder   = rem_reg;
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=8). Expected results come from
// plain integer division. The bench checks results, flags, latency and
// busy time for directed and random operands. It also covers start being
// ignored while busy, abort on reset, and back-to-back starts.
// Signed cases are added when SEQ_DIVIDER_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         signed_op = 1'b0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int passes = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, observed, observed, expected, expected);
  endtask

  // Present operands at the falling edge and hold start through one
  // rising edge. Returns #1 after that edge, which is the start edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sop);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = sop;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // The cycle right after the start edge counts as latency 1. busyCycles
  // counts the sampled cycles before done in which busy was high.
  task automatic waitDone(output int lat, output int busyCycles);
    lat = 1;
    busyCycles = 0;
    while (!done && lat < 40) begin
      if (busy) busyCycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) checkOutput("done_timeout", {31'b0, done}, 32'd1);
  endtask

  // Reference model: truncating integer division; divide by zero gives
  // all ones and passes the dividend through as the remainder.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sop, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic dz,
                          output int lat, output int busyLen);
    int sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1; busyLen = 0;
    end else if (sop) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
      lat = W + 2; busyLen = W + 1;
    end else begin
      q = W'(int'(a) / int'(b)); r = W'(int'(a) % int'(b)); dz = 1'b0;
      lat = W + 1; busyLen = W;
    end
  endtask

  // Run one divide and compare everything observable against the model.
  task automatic runAndCheck(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic sop,
                             input bit timing);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, ebusy, lat, bc, inv;
    refModel(a, b, sop, eq, er, edz, elat, ebusy);
    applyStimulus(a, b, sop);
    waitDone(lat, bc);
    checkOutput({tag, "_quot"}, 32'(quotient), 32'(eq));
    checkOutput({tag, "_rem"}, 32'(remainder), 32'(er));
    checkOutput({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
    if (timing) begin
      checkOutput({tag, "_lat"}, 32'(lat), 32'(elat));
      checkOutput({tag, "_busy"}, 32'(bc), 32'(ebusy));
    end
    if (!sop && b != 0) begin
      inv = int'(quotient) * int'(b) + int'(remainder);
      checkOutput({tag, "_inv"}, 32'(inv), 32'(a));
      checkOutput({tag, "_remlt"}, {31'b0, (remainder < b)}, 32'd1);
    end
  endtask

  initial begin
    int doneSeen;
    int lat;
    int bc;
    logic [W-1:0] ra, rb;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    checkOutput("rst_quot", 32'(quotient), 32'd0);
    checkOutput("rst_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function and latency.
    runAndCheck("200by7", 8'd200, 8'd7, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("done_pulse", {31'b0, done}, 32'd0);
    checkOutput("hold_quot", 32'(quotient), 32'd28);

    // Divide by zero, then flag cleared by the next divide.
    runAndCheck("5by0", 8'd5, 8'd0, 1'b0, 1'b1);
    runAndCheck("6by3", 8'd6, 8'd3, 1'b0, 1'b1);

    // Boundaries.
    runAndCheck("7by9", 8'd7, 8'd9, 1'b0, 1'b1);
    runAndCheck("255by1", 8'd255, 8'd1, 1'b0, 1'b1);
    runAndCheck("255by255", 8'd255, 8'd255, 1'b0, 1'b1);
    runAndCheck("0by13", 8'd0, 8'd13, 1'b0, 1'b1);

    // Start pulsed mid-divide with other operands must be ignored.
    applyStimulus(8'd200, 8'd7, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat, bc);
    checkOutput("ign_quot", 32'(quotient), 32'd28);
    checkOutput("ign_rem", 32'(remainder), 32'd4);

    // Reset in the middle of a divide: outputs cleared, no done pulse.
    applyStimulus(8'd100, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_quot", 32'(quotient), 32'd0);
    checkOutput("abort_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("abort_nodone", 32'(doneSeen), 32'd0);

    // Back-to-back: the second start lands in the DONE cycle of the first.
    runAndCheck("b2b_a", 8'd50, 8'd6, 1'b0, 1'b1);
    runAndCheck("b2b_b", 8'd77, 8'd8, 1'b0, 1'b1);
    runAndCheck("b2b_zero", 8'd9, 8'd0, 1'b0, 1'b1);
    runAndCheck("b2b_c", 8'd129, 8'd2, 1'b0, 1'b1);

    // Random unsigned operands, with divide by zero mixed in.
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
      runAndCheck("rnd", ra, rb, 1'b0, 1'b1);
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Signed mode.
    runAndCheck("s_m100by7", 8'h9C, 8'd7, 1'b1, 1'b1);
    runAndCheck("s_m128bym1", 8'h80, 8'hFF, 1'b1, 1'b1);
    runAndCheck("s_m5by0", 8'hFB, 8'd0, 1'b1, 1'b1);
    runAndCheck("s_off", 8'h9C, 8'd7, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
      runAndCheck("s_rnd", ra, rb, 1'b1, 1'b1);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
